// File: rtl/r_arb_pkg.sv
// Shared types and helpers for the burst-granular R-channel arbiter.
// Optional feature macro: R_ARB_SRC_TAG_EN (source index prepended to r_out.id).
package r_arb_pkg;

    // Arbiter FSM: IDLE picks a winner, LOCKED holds it until its RLAST beat.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of a source index; never narrower than one bit.
    function automatic int src_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/r_if.sv
// AXI-style R channel bundle.
// valid/ready: a beat transfers on a cycle where valid and ready are both
// high; the sender holds id/data/resp/last stable while valid is high and
// ready is low.
interface r_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 64,
    parameter int RESP_W = 2
);
    logic              valid;
    logic              ready;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;

    modport sender   (output valid, id, data, resp, last, input  ready);
    modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: returns the first asserted
// request at or above ptr, wrapping modulo NUM_SRC.
module rr_pick
    import r_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = src_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   idx,
    output logic               any
);

    logic [SRC_W-1:0] cand;

    // Scan from ptr upward; the first hit wins and later hits are masked by any.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = SRC_W'((int'(ptr) + i) % NUM_SRC);
            if (req[cand] & ~any) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/r_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one R return path among
// NUM_SRC beat sources. A grant is held until the granted source's RLAST
// beat transfers, so bursts never interleave; one IDLE bubble per burst.
// Optional feature macro: R_ARB_SRC_TAG_EN -- r_out.id = {gnt_q, src_id}.
module r_burst_arbiter
    import r_arb_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int ID_WIDTH   = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int RESP_WIDTH = 2,
    localparam int SRC_W      = src_idx_w(NUM_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]    src_id,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
    input  logic [NUM_SRC*RESP_WIDTH-1:0]  src_resp,
    input  logic [NUM_SRC-1:0]             src_last,
    r_if.sender                            r_out,
    output logic                           busy,
    output logic [SRC_W-1:0]               grant_idx
);

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] gnt_q, gnt_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_any;
    logic             out_valid;

    logic [ID_WIDTH-1:0]   id_arr   [NUM_SRC];
    logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
    logic [RESP_WIDTH-1:0] resp_arr [NUM_SRC];

    // Unpack the flat per-source buses into indexable arrays for the beat mux.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign id_arr[k]   = src_id[k*ID_WIDTH +: ID_WIDTH];
        assign data_arr[k] = src_data[k*DATA_WIDTH +: DATA_WIDTH];
        assign resp_arr[k] = src_resp[k*RESP_WIDTH +: RESP_WIDTH];
    end

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state, grant hand-off and per-source ready generation.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        src_ready = '0;
        out_valid = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                out_valid        = src_valid[gnt_q];
                src_ready[gnt_q] = r_out.ready;
                // Release only on the RLAST transfer; next winner is picked in IDLE.
                if (out_valid & r_out.ready & src_last[gnt_q]) begin
                    rr_ptr_d = (gnt_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_q + SRC_W'(1);
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign r_out.valid = out_valid;
    assign r_out.data  = data_arr[gnt_q];
    assign r_out.resp  = resp_arr[gnt_q];
    assign r_out.last  = src_last[gnt_q];
`ifdef R_ARB_SRC_TAG_EN
    assign r_out.id    = {gnt_q, id_arr[gnt_q]};
`else
    assign r_out.id    = id_arr[gnt_q];
`endif

    assign busy      = (state_q == ARB_LOCKED);
    assign grant_idx = gnt_q;

endmodule

// File: tb/tb_r_burst_arbiter.sv
// Self-checking bench for r_burst_arbiter: scenario tasks with a beat
// scoreboard and an expected-grant-order queue.
module tb_r_burst_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int ID_WIDTH   = 4;
    localparam int DATA_WIDTH = 64;
    localparam int RESP_WIDTH = 2;
    localparam int SRC_W      = 2;
    localparam int DEPTH      = 32;
`ifdef R_ARB_SRC_TAG_EN
    localparam int OUT_ID_W = SRC_W + ID_WIDTH;
    localparam logic [OUT_ID_W-1:0] TAG_EXP = 6'h35;
`else
    localparam int OUT_ID_W = ID_WIDTH;
    localparam logic [OUT_ID_W-1:0] TAG_EXP = 4'h5;
`endif
    localparam int EXP_W = OUT_ID_W + DATA_WIDTH + RESP_WIDTH + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } beat_t;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC-1:0]            src_ready;
    logic [NUM_SRC*ID_WIDTH-1:0]   src_id;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC*RESP_WIDTH-1:0] src_resp;
    logic [NUM_SRC-1:0]            src_last;
    logic                          busy;
    logic [SRC_W-1:0]              grant_idx;

    r_if #(.ID_W(OUT_ID_W), .DATA_W(DATA_WIDTH), .RESP_W(RESP_WIDTH)) r_out_if ();

    r_burst_arbiter #(
        .NUM_SRC(NUM_SRC), .ID_WIDTH(ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .RESP_WIDTH(RESP_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_id(src_id), .src_data(src_data), .src_resp(src_resp), .src_last(src_last),
        .r_out(r_out_if), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    // ---------------- source model and scoreboard ----------------
    beat_t            src_mem [NUM_SRC][DEPTH];
    int               src_rd  [NUM_SRC];
    int               src_wr  [NUM_SRC];
    logic [NUM_SRC-1:0] src_en;
    logic [EXP_W-1:0] exp_q[$];
    int               exp_grant_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               burst_seq = 0;

    function automatic logic [OUT_ID_W-1:0] exp_id(input int k, input logic [ID_WIDTH-1:0] id);
        logic [SRC_W+ID_WIDTH-1:0] full;
        full = {SRC_W'(k), id};
        return full[OUT_ID_W-1:0];
    endfunction

    // Queue a burst on source k; the first n_exp beats are expected on r_out.
    task automatic push_burst(input int k, input int n, input logic [ID_WIDTH-1:0] id, input int n_exp);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.id   = id;
            b.data = {8'(k), 8'(burst_seq), 16'(i), 32'($urandom)};
            b.resp = RESP_WIDTH'($urandom_range(0, 3));
            b.last = (i == n - 1);
            src_mem[k][src_wr[k]] = b;
            src_wr[k]++;
            if (i < n_exp) exp_q.push_back({exp_id(k, id), b.data, b.resp, b.last});
        end
        exp_grant_q.push_back(k);
        burst_seq++;
    endtask

    task automatic drive_sources();
        beat_t b;
        for (int k = 0; k < NUM_SRC; k++) begin
            b = src_mem[k][src_rd[k] % DEPTH];
            src_valid[k] = src_en[k] & (src_rd[k] < src_wr[k]);
            src_id[k*ID_WIDTH +: ID_WIDTH]       = b.id;
            src_data[k*DATA_WIDTH +: DATA_WIDTH] = b.data;
            src_resp[k*RESP_WIDTH +: RESP_WIDTH] = b.resp;
            src_last[k] = b.last;
        end
    endtask

    // Drive inputs on the falling edge, then sample outputs 1 time unit later.
    task automatic step_sample(input logic rdy);
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp;
        @(negedge clk);
        r_out_if.ready = rdy;
        drive_sources();
        #1;
        if ((r_out_if.valid === 1'b1) && (r_out_if.ready === 1'b1)) begin
            n_checks++;
            act = {r_out_if.id, r_out_if.data, r_out_if.resp, r_out_if.last};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_beat: got id=%h data=%h, expected no beat", r_out_if.id, r_out_if.data);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL sb_beat: got %h, expected %h", act, exp);
                end
            end
        end
    endtask

    // Advance source read pointers for beats accepted at the rising edge.
    task automatic step_commit();
        logic [NUM_SRC-1:0] fire;
        fire = src_valid & src_ready;
        @(posedge clk);
        for (int k = 0; k < NUM_SRC; k++) if (fire[k] === 1'b1) src_rd[k]++;
    endtask

    // Run queued traffic with ready=1 until drained, checking grant order and the bubble.
    task automatic run_traffic(input int max_cycles);
        logic prev_busy;
        logic prev_last;
        logic done;
        int   g;
        prev_busy = busy;
        prev_last = 1'b0;
        done      = (exp_q.size() == 0) && (exp_grant_q.size() == 0);
        for (int c = 0; (c < max_cycles) && !done; c++) begin
            step_sample(1'b1);
            if (prev_last) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubble_after_last: busy=%b, expected 0", busy);
                end
            end
            if ((busy === 1'b1) && (prev_busy !== 1'b1)) begin
                n_checks++;
                if (exp_grant_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_unexpected: got grant %0d, expected none", grant_idx);
                end else begin
                    g = exp_grant_q.pop_front();
                    if (grant_idx !== SRC_W'(g)) begin
                        n_fail++;
                        $display("FAIL grant_order: got %0d, expected %0d", grant_idx, g);
                    end
                end
            end
            prev_last = r_out_if.valid & r_out_if.ready & r_out_if.last;
            prev_busy = busy;
            step_commit();
            done = (exp_q.size() == 0) && (exp_grant_q.size() == 0);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL traffic_timeout: beats left %0d, grants left %0d, expected 0/0", exp_q.size(), exp_grant_q.size());
        end
    endtask

    task automatic check_grant_now(input string name, input int g_exp);
        int g;
        n_checks++;
        g = (exp_grant_q.size() != 0) ? exp_grant_q.pop_front() : -1;
        if ((busy !== 1'b1) || (grant_idx !== SRC_W'(g_exp)) || (g != g_exp)) begin
            n_fail++;
            $display("FAIL %s: busy=%b grant=%0d, expected busy=1 grant=%0d", name, busy, grant_idx, g_exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        src_en = '0;
        src_valid = '0;
        r_out_if.ready = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        exp_q.delete();
        exp_grant_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        src_valid = '1;
        src_last = '0;
        src_id = '0;
        src_data = '0;
        src_resp = '0;
        r_out_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ((busy !== 1'b0) || (grant_idx !== '0) || (r_out_if.valid !== 1'b0) || (src_ready !== '0)) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b grant=%0d valid=%b src_ready=%b, expected 0/0/0/0000",
                     busy, grant_idx, r_out_if.valid, src_ready);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        push_burst(2, 4, 4'h9, 4);
        src_en = '1;
        for (int c = 0; c < 6; c++) begin
            step_sample(1'b1);
            if (c == 0) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_c0_idle: busy=%b, expected 0", busy);
                end
            end
            if (c == 1) check_grant_now("single_c1_grant", 2);
            if ((c >= 1) && (c <= 4)) begin
                n_checks++;
                if ((r_out_if.valid !== 1'b1) || (r_out_if.last !== (c == 4))) begin
                    n_fail++;
                    $display("FAIL single_beat_c%0d: valid=%b last=%b, expected 1/%b", c, r_out_if.valid, r_out_if.last, c == 4);
                end
            end
            if (c == 5) begin
                n_checks++;
                if ((busy !== 1'b0) || (grant_idx !== 2'd2) || (r_out_if.valid !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL single_c5_idle: busy=%b grant=%0d valid=%b, expected 0/2/0", busy, grant_idx, r_out_if.valid);
                end
            end
            step_commit();
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: beats left %0d, expected 0", exp_q.size());
        end
        // rr_ptr must now be 3: src 3 beats src 2 when both request.
        push_burst(3, 1, 4'h3, 1);
        push_burst(2, 1, 4'h2, 1);
        run_traffic(20);
    endtask

    task automatic test_round_robin();
        do_reset();
        push_burst(0, 2, 4'h1, 2);
        push_burst(1, 2, 4'h2, 2);
        push_burst(2, 2, 4'h3, 2);
        push_burst(3, 2, 4'h4, 2);
        push_burst(0, 2, 4'h5, 2);
        src_en = '1;
        run_traffic(60);
    endtask

    task automatic test_backpressure();
        logic rdy;
        beat_t hb;
        do_reset();
        push_burst(1, 3, 4'hA, 3);
        push_burst(2, 1, 4'hB, 1);
        push_burst(3, 1, 4'hC, 1);
        src_en = '1;
        for (int c = 0; c < 6; c++) begin
            rdy = (c == 0) ? 1'b1 : (c % 2 == 1);
            step_sample(rdy);
            if (c == 1) check_grant_now("bp_grant", 1);
            if (c >= 1) begin
                n_checks++;
                if (src_ready !== (4'(rdy) << 1)) begin
                    n_fail++;
                    $display("FAIL bp_src_ready_c%0d: got %b, expected %b", c, src_ready, 4'(rdy) << 1);
                end
            end
            if ((c >= 1) && !rdy) begin
                hb = src_mem[1][src_rd[1]];
                n_checks++;
                if ((r_out_if.valid !== 1'b1) || (r_out_if.data !== hb.data)) begin
                    n_fail++;
                    $display("FAIL bp_stall_hold_c%0d: valid=%b data=%h, expected 1/%h", c, r_out_if.valid, r_out_if.data, hb.data);
                end
            end
            step_commit();
        end
        run_traffic(20);
    endtask

    task automatic test_wrap();
        do_reset();
        src_en = '1;
        push_burst(2, 1, 4'h1, 1);   // leaves rr_ptr at 3
        run_traffic(10);
        push_burst(0, 1, 4'h2, 1);   // only src 0 with rr_ptr=3
        run_traffic(10);
        push_burst(3, 1, 4'h3, 1);   // rr_ptr wraps 3 -> 0
        run_traffic(10);
        push_burst(0, 1, 4'h4, 1);   // 0 and 1 together: 0 wins at ptr 0
        push_burst(1, 1, 4'h5, 1);
        run_traffic(10);
    endtask

    task automatic test_mid_reset();
        do_reset();
        src_en = '1;
        push_burst(1, 1, 4'h7, 1);   // leaves rr_ptr at 2
        run_traffic(10);
        push_burst(0, 4, 4'h8, 2);   // only 2 of 4 beats get out
        for (int c = 0; c < 3; c++) begin
            step_sample(1'b1);
            if (c == 1) check_grant_now("midrst_grant", 0);
            step_commit();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ((busy !== 1'b0) || (r_out_if.valid !== 1'b0) || (src_ready !== '0)) begin
            n_fail++;
            $display("FAIL midrst_drop: busy=%b valid=%b src_ready=%b, expected 0/0/0000", busy, r_out_if.valid, src_ready);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_beats: beats left %0d, expected 0", exp_q.size());
        end
        src_en = '0;
        src_valid = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        exp_grant_q.delete();
        @(negedge clk);
        rst = 1'b0;
        src_en = '1;
        push_burst(0, 1, 4'h1, 1);   // rr_ptr back at 0: 0 before 2
        push_burst(2, 1, 4'h2, 1);
        run_traffic(10);
    endtask

    task automatic test_src_tag();
        do_reset();
        src_en = '1;
        push_burst(3, 1, 4'h5, 1);
        for (int c = 0; c < 3; c++) begin
            step_sample(1'b1);
            if (c == 1) begin
                check_grant_now("tag_grant", 3);
                n_checks++;
                if (r_out_if.id !== TAG_EXP) begin
                    n_fail++;
                    $display("FAIL tag_id: got %h, expected %h", r_out_if.id, TAG_EXP);
                end
            end
            step_commit();
        end
    endtask

    initial begin
        src_en = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_src_tag();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
